// File: rtl/simple_uart_rx.sv
// UART receiver: start bit, DATA_N_BIT data bits LSB first, even parity, one stop bit.
// Define SIMPLE_UART_RX_MAJORITY_EN for 2-of-3 majority sampling of every bit (needs CLK_PER_BIT >= 6).
module simple_uart_rx #(
    parameter int DATA_N_BIT = 8,
    parameter int BAUD_RATE  = 10,
    parameter int F_CLK_Hz   = 100
) (
    input  logic                  clk,
    input  logic                  sync_rst_n,
    input  logic                  uart_din,
    output logic [DATA_N_BIT-1:0] dout,
    output logic                  dout_valid,
    output logic                  parity_err,
    output logic                  frame_err
);

    localparam int CLK_PER_BIT = F_CLK_Hz / BAUD_RATE;
    localparam int CNT_W       = $clog2(CLK_PER_BIT + 1) + 1;
    localparam int BIT_W       = $clog2(DATA_N_BIT) + 1;

    // Majority decisions land one cycle after the centre sample; reloading the
    // counter with 1 keeps the decision-to-decision spacing at CLK_PER_BIT.
`ifdef SIMPLE_UART_RX_MAJORITY_EN
    localparam int              MIN_CPB    = 6;
    localparam logic [CNT_W-1:0] START_DEC  = CNT_W'(CLK_PER_BIT / 2);
    localparam logic [CNT_W-1:0] BIT_DEC    = CNT_W'(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(1);
`else
    localparam int              MIN_CPB    = 4;
    localparam logic [CNT_W-1:0] START_DEC  = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_DEC    = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = '0;
`endif

    generate
        if (CLK_PER_BIT < MIN_CPB) begin : g_cpb_check
            $error("simple_uart_rx: F_CLK_Hz/BAUD_RATE is too small");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic                  sync1_q;
    logic                  sync2_q;
    logic                  line_d_q;
    logic [2:0]            line_ok_q;
    logic                  line_s;
    logic                  bit_sample;
    state_t                state_q,      state_d;
    logic [CNT_W-1:0]      clk_cnt_q,    clk_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [DATA_N_BIT-1:0] shift_q,      shift_d;
    logic                  par_bit_q,    par_bit_d;
    logic [DATA_N_BIT-1:0] dout_q,       dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q,  frame_err_d;

    assign line_s = sync2_q;

`ifdef SIMPLE_UART_RX_MAJORITY_EN
    logic line_dd_q;
    assign bit_sample = (line_dd_q & line_d_q) | (line_dd_q & line_s) | (line_d_q & line_s);
`else
    assign bit_sample = line_s;
`endif

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q + CNT_W'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                // line_ok_q[2] masks the reset-value 1s still draining out of the synchroniser
                if (line_ok_q[2] && line_d_q && !line_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (clk_cnt_q == START_DEC) begin
                    if (!bit_sample) begin
                        state_d   = DATA;
                        clk_cnt_d = CNT_RELOAD;
                    end else begin
                        state_d   = IDLE;
                        clk_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_DEC) begin
                    clk_cnt_d = CNT_RELOAD;
                    for (int i = 0; i < DATA_N_BIT; i++) begin
                        if (bit_cnt_q == BIT_W'(i)) begin
                            shift_d[i] = bit_sample;
                        end
                    end
                    if (bit_cnt_q == BIT_W'(DATA_N_BIT - 1)) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (clk_cnt_q == BIT_DEC) begin
                    par_bit_d = bit_sample;
                    state_d   = STOP;
                    clk_cnt_d = CNT_RELOAD;
                end
            end
            STOP: begin
                // Leave at the stop-bit midpoint so a back-to-back start edge is not missed
                if (clk_cnt_q == BIT_DEC) begin
                    state_d      = IDLE;
                    clk_cnt_d    = '0;
                    dout_d       = shift_q;
                    dout_valid_d = 1'b1;
                    parity_err_d = par_bit_q ^ (^shift_q);
                    frame_err_d  = ~bit_sample;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            line_d_q     <= 1'b1;
            line_ok_q    <= '0;
`ifdef SIMPLE_UART_RX_MAJORITY_EN
            line_dd_q    <= 1'b1;
`endif
            state_q      <= IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= uart_din;
            sync2_q      <= sync1_q;
            line_d_q     <= line_s;
            line_ok_q    <= {line_ok_q[1:0], 1'b1};
`ifdef SIMPLE_UART_RX_MAJORITY_EN
            line_dd_q    <= line_d_q;
`endif
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_simple_uart_rx.sv
// Scoreboard bench for simple_uart_rx at default parameters (10 clk per bit).
// Expected words are queued when a frame is driven and popped on each dout_valid pulse.
module tb_simple_uart_rx;

    localparam int CPB     = 10;
    localparam int LAT_MIN = 105;
    localparam int LAT_MAX = 110;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         start_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       sync_rst_n;
    logic       uart_din;
    logic [7:0] dout;
    logic       dout_valid;
    logic       parity_err;
    logic       frame_err;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   lat;
    exp_t exp_q[$];
    exp_t mon_e;

    simple_uart_rx dut (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .uart_din   (uart_din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; glitch inverts the centre cycle of every bit after the start bit.
    task automatic frame_raw(input logic [7:0] data, input bit par_flip, input bit stop_val, input bit glitch);
        logic [10:0] bits;
        bits = {stop_val, (^data) ^ par_flip, data, 1'b0};
        for (int s = 0; s < 11; s++) begin
            for (int c = 0; c < CPB; c++) begin
                uart_din = bits[s] ^ (glitch && s > 0 && c == CPB / 2);
                @(posedge clk);
                #1;
            end
        end
        uart_din = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit par_flip, input bit stop_val);
        exp_q.push_back('{data: data, perr: par_flip, ferr: ~stop_val, start_cyc: cyc});
        frame_raw(data, par_flip, stop_val, 1'b0);
    endtask

    always @(negedge clk) begin
        if (dout_valid) begin
            check_val("valid_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                lat   = cyc - mon_e.start_cyc;
                check_val("dout", dout, mon_e.data);
                check_val("parity_err", parity_err, mon_e.perr);
                check_val("frame_err", frame_err, mon_e.ferr);
                check_val("latency_in_window", lat >= LAT_MIN && lat <= LAT_MAX, 1);
                $display("rx word 0x%02h perr=%0d ferr=%0d latency=%0d", dout, parity_err, frame_err, lat);
            end
        end else begin
            check_val("parity_err_unqualified", parity_err, 0);
            check_val("frame_err_unqualified", frame_err, 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] bits;

        // Reset with the line held low, then keep it low: no frame may start
        sync_rst_n = 1'b0;
        uart_din   = 1'b0;
        wait_cycles(3);
        check_val("rst_dout", dout, 0);
        check_val("rst_dout_valid", dout_valid, 0);
        check_val("rst_parity_err", parity_err, 0);
        check_val("rst_frame_err", frame_err, 0);
        sync_rst_n = 1'b1;
        wait_cycles(500);
        uart_din = 1'b1;
        wait_cycles(30);

        send_frame(8'hA5, 1'b0, 1'b1);
        wait_cycles(20);

        // Back-to-back, no idle gap
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_cycles(20);

        send_frame(8'h3C, 1'b1, 1'b1);
        wait_cycles(20);
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_cycles(20);

        // Short low pulse: false start, then a clean frame
        uart_din = 1'b0;
        wait_cycles(3);
        uart_din = 1'b1;
        wait_cycles(20);
        send_frame(8'h96, 1'b0, 1'b1);
        wait_cycles(20);

        // Reset in the middle of data bit 4 of 0x81
        bits = {1'b1, 1'b0, 8'h81, 1'b0};
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < ((s == 4) ? CPB / 2 : CPB); c++) begin
                uart_din = bits[s];
                @(posedge clk);
                #1;
            end
        end
        sync_rst_n = 1'b0;
        uart_din   = 1'b1;
        wait_cycles(1);
        sync_rst_n = 1'b1;
        check_val("midrst_dout", dout, 0);
        check_val("midrst_dout_valid", dout_valid, 0);
        check_val("midrst_parity_err", parity_err, 0);
        check_val("midrst_frame_err", frame_err, 0);
        wait_cycles(150);
        send_frame(8'h42, 1'b0, 1'b1);
        wait_cycles(20);

        // Single-cycle glitch at the centre of every bit of 0x55
`ifdef SIMPLE_UART_RX_MAJORITY_EN
        exp_q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b0, start_cyc: cyc});
`else
        exp_q.push_back('{data: 8'hAA, perr: 1'b1, ferr: 1'b1, start_cyc: cyc});
`endif
        frame_raw(8'h55, 1'b0, 1'b1, 1'b1);
        wait_cycles(150);

        check_val("all_expected_words_seen", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/simple_uart_rx.md
Name: simple_uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's UART transmitter.
- Deserialises frames of: 1 start bit (0), DATA_N_BIT data bits LSB first, 1 even-parity bit (XOR of the data bits), 1 stop bit (1).
- Delivers each received word as a one-cycle valid pulse, with parity and framing error flags.
- Sits between the async serial pin and the byte-consuming logic; a TX instance with identical parameters looped onto uart_din must round-trip all data.

Parameters:
- DATA_N_BIT, 8, data bits per frame.
- BAUD_RATE, 10, line bit rate in bit/s.
- F_CLK_Hz, 100, clk frequency in Hz.
- Derived: CLK_PER_BIT = F_CLK_Hz/BAUD_RATE, integer division. Must be >= 4 (elaboration-time assertion).

Ports:
- clk  input  1  system clock; single clock domain.
- sync_rst_n  input  1  reset, synchronous, active-low.
- uart_din  input  1  asynchronous serial line; idle high.
- dout  output  DATA_N_BIT  last received data word.
- dout_valid  output  1  one-cycle pulse; dout and the error flags are valid in this cycle.
- parity_err  output  1  received parity bit != ^data; qualified by dout_valid.
- frame_err  output  1  stop bit sampled as 0; qualified by dout_valid.

Behaviour:
- Interface (already decided): one clock, clk; reset sync_rst_n is synchronous and active-low.
- Input synchroniser: uart_din passes through 2 flops (reset value 1) giving line_s. A third flop, line_d, holds the previous line_s for edge detection.
- Reset values: dout=0, dout_valid=0, parity_err=0, frame_err=0, state=IDLE, all counters 0.
- Reset mid-frame: the partial frame is discarded and no dout_valid is produced.
- States: IDLE, START, DATA, PARITY, STOP. clk_cnt is a free-running counter, cleared on every state transition.
- IDLE:
  - bit_cnt cleared.
  - Start detect requires a falling edge (line_d=1, line_s=0) -> START.
  - A line held low (break, or low at reset release) never starts a frame.
- START:
  - At clk_cnt == CLK_PER_BIT/2-1, sample line_s.
  - Sample 0 -> DATA.
  - Sample 1 -> IDLE (glitch or false start); no output.
- DATA:
  - At clk_cnt == CLK_PER_BIT-1, sample line_s into shift_reg[bit_cnt] (LSB first).
  - bit_cnt != DATA_N_BIT-1 -> bit_cnt+1; otherwise -> PARITY.
- PARITY: at clk_cnt == CLK_PER_BIT-1, sample into par_bit -> STOP.
- STOP: at clk_cnt == CLK_PER_BIT-1, sample the stop bit, then in the next cycle:
  - dout <= shift_reg
  - dout_valid <= 1
  - parity_err <= par_bit ^ (^shift_reg)
  - frame_err <= ~stop_sample
  - state -> IDLE
- Mid-bit sampling and early return: all samples land near mid-bit. Returning to IDLE at the stop-bit midpoint lets a back-to-back start edge be caught.
- Output rules:
  - dout_valid is high for exactly 1 cycle per completed frame.
  - parity_err and frame_err are 0 whenever dout_valid=0.
  - dout holds its value until the next completed frame.
- Errored frames: data is still delivered, with the flags set. Consumers decide whether to drop it.
- No backpressure: a consumer that misses the pulse loses the word.
- Latency, start edge at uart_din to dout_valid:
  - 2 (sync) + 1 + CLK_PER_BIT/2 + (DATA_N_BIT+2)*CLK_PER_BIT (+/-1) clk.
  - Defaults: ~108 cycles; bench accepts window 105..110.
- Counter widths: clk_cnt is $clog2(CLK_PER_BIT+1)+1 bits; bit_cnt is $clog2(DATA_N_BIT)+1 bits. No wrap occurs within a frame.

Optional Feature:
- Macro: SIMPLE_UART_RX_MAJORITY_EN.
- Defined:
  - Each data, parity and stop bit is the majority of 3 samples of line_s, taken at clk_cnt = CLK_PER_BIT-2, CLK_PER_BIT-1 and CLK_PER_BIT (the decision cycle).
  - The START check is also 2-of-3 around CLK_PER_BIT/2-1.
  - Adds 1 cycle per bit period to the decision point only; bit period timing is unchanged. Requires CLK_PER_BIT >= 6.
  - Single-cycle line glitches are rejected.
- Undefined: single-sample decision as described in Behaviour.

Test Plan:
- Ideal frame for 0xA5 (parity 0, stop 1), defaults -> one dout_valid pulse; dout=0xA5, parity_err=0, frame_err=0; latency within 105..110 cycles.
- Two frames back-to-back, 0x00 then 0xFF, with no idle gap -> two pulses, dout=0x00 then 0xFF, no errors.
- Frame 0x3C with parity bit forced to 1 -> dout=0x3C, parity_err=1, frame_err=0. Frame 0x3C with stop bit 0 -> frame_err=1.
- Line low pulse of 3 cycles then high -> false start; no dout_valid, and state returns to IDLE before the next frame. Line held low 500 cycles after reset -> no dout_valid.
- sync_rst_n asserted for 1 cycle in the middle of data bit 4 of 0x81 -> no pulse for that frame, outputs 0. A following clean frame 0x42 is received correctly.
- With SIMPLE_UART_RX_MAJORITY_EN: frame 0x55 with a 1-cycle inverted glitch at the centre of every bit -> dout=0x55, no errors. Without the macro, the same stimulus corrupts dout.
